cordic_vectoring_iter: RTL

Iterative (one micro-rotation per clock) circular-vectoring CORDIC. It is the inverse direction of the rotation pipeline: it takes a Q3.29 vector (x, y) and returns its magnitude and phase, phase = atan2(y, x).
- Shares the Q3.29 atan table and the K constant with the pipelined CORDIC.
- Sits downstream of the pipeline, or standalone in the DSP path where area matters more than throughput.
- Uses valid/ready handshakes on both sides.

---
 rtl/cordic_vectoring_iter_if.sv | 24 ++
 rtl/cordic_vectoring_iter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_iter_if.sv
// Handshake bundle for the iterative vectoring CORDIC: input vector channel and
// magnitude/phase result channel, both valid/ready.
interface cordic_vectoring_iter_if #(
  parameter int M = 32
);
  logic                in_valid;
  logic                in_ready;
  logic signed [M-1:0] x_in;
  logic signed [M-1:0] y_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [M-1:0] mag;
  logic signed [M-1:0] phase;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, mag, phase
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, mag, phase
  );
endinterface

// File: rtl/cordic_vectoring_iter.sv
// Iterative circular-vectoring CORDIC, one micro-rotation per clock:
// Q3.29 (x, y) -> magnitude and atan2(y, x).
module cordic_vectoring_iter #(
  parameter int M = 32,
  parameter int N = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  cordic_vectoring_iter_if.slave bus
);
  localparam int W  = M + 2;
  localparam int PW = 2 * M + 2;
  localparam logic signed [M-1:0] HALF_PI = M'(32'h3243F6A9);
  // 1/K for the converged circular gain (~0.6072529), Q3.29
  localparam logic signed [M-1:0] K_INV   = M'(32'h136E9DB5);

  typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

  state_t              state, state_nxt;
  logic [4:0]          iter;
  logic signed [W-1:0] x_acc, y_acc;
  logic signed [M-1:0] z_acc;
  logic                zero_flag;
  logic signed [M-1:0] mag_q, phase_q;

  logic signed [W-1:0]  x_ext, y_ext, x_pre, y_pre;
  logic signed [M-1:0]  z_pre;
  logic signed [W-1:0]  x_sh, y_sh, x_nxt, y_nxt;
  logic signed [M-1:0]  atan_i, z_nxt;
  logic signed [PW-1:0] prod;

  function automatic logic signed [M-1:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    return M'(32'h1921FB54);
      5'd1:    return M'(32'h0ED63383);
      5'd2:    return M'(32'h07D6DD7E);
      5'd3:    return M'(32'h03FAB753);
      5'd4:    return M'(32'h01FF55BB);
      5'd5:    return M'(32'h00FFEAAE);
      5'd6:    return M'(32'h007FFD55);
      5'd7:    return M'(32'h003FFFAB);
      5'd8:    return M'(32'h001FFFF5);
      5'd9:    return M'(32'h000FFFFF);
      // beyond i=9 atan(2^-i) rounds to exactly 2^-i
      default: return (idx <= 5'd29) ? (M'(32'd1) << (5'd29 - idx)) : '0;
    endcase
  endfunction

  function automatic logic signed [M-1:0] sat_mag(input logic signed [PW-1:0] v);
    if (v[PW-1])
      return '0;
    if (|v[PW-2:M-1])
      return {1'b0, {(M-1){1'b1}}};
    return v[M-1:0];
  endfunction

  assign x_ext = {{2{bus.x_in[M-1]}}, bus.x_in};
  assign y_ext = {{2{bus.y_in[M-1]}}, bus.y_in};

  // Fold left-half-plane vectors into the right half so the micro-rotations converge
  always_comb begin
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (bus.x_in[M-1]) begin
      if (!bus.y_in[M-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = HALF_PI;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = -HALF_PI;
      end
    end
  end

  always_comb begin
    x_sh   = x_acc >>> iter;
    y_sh   = y_acc >>> iter;
    atan_i = atan_lut(iter);
    if (!y_acc[W-1]) begin
      x_nxt = x_acc + y_sh;
      y_nxt = y_acc - x_sh;
      z_nxt = z_acc + atan_i;
    end else begin
      x_nxt = x_acc - y_sh;
      y_nxt = y_acc + x_sh;
      z_nxt = z_acc - atan_i;
    end
  end

  assign prod = (PW'(x_acc) * PW'(K_INV)) >>> 29;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = ITER;
      ITER:    if (iter == 5'(N - 1)) state_nxt = SCALE;
      SCALE:   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter      <= '0;
      x_acc     <= '0;
      y_acc     <= '0;
      z_acc     <= '0;
      zero_flag <= 1'b0;
      mag_q     <= '0;
      phase_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          x_acc     <= x_pre;
          y_acc     <= y_pre;
          z_acc     <= z_pre;
          zero_flag <= (bus.x_in == '0) && (bus.y_in == '0);
          iter      <= '0;
        end
        ITER: begin
          x_acc <= x_nxt;
          y_acc <= y_nxt;
          z_acc <= z_nxt;
          iter  <= iter + 5'd1;
        end
        SCALE: begin
          mag_q   <= zero_flag ? '0 : sat_mag(prod);
          phase_q <= zero_flag ? '0 : z_acc;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.mag       = mag_q;
  assign bus.phase     = phase_q;
endmodule
